// File: rtl/alu_exec.sv
// alu_exec: registered execute-stage ALU with valid/ready on both sides.
// Define ALU_MUL_EN to enable the iterative shift-add multiplier on code 8.
module alu_exec #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctl,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);
`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif
   state_t state, state_nx, go_st;
   logic accept, is_mul, bad, mul_done;
   logic [WIDTH-1:0] alu_res, mul_res;
   assign in_ready = state == IDLE || (state == DONE && out_ready);
   assign out_valid = state == DONE;
   assign accept = in_valid && in_ready;
   always_comb begin
      bad = 1'b0;
      is_mul = 1'b0;
      alu_res = '0;
      case (alu_ctl)
         4'd0: alu_res = op_a & op_b;
         4'd1: alu_res = op_a | op_b;
         4'd2: alu_res = op_a + op_b;
         4'd3, 4'd6: alu_res = op_a - op_b;
         4'd7: alu_res = WIDTH'($signed(op_a) < $signed(op_b));
         4'd12: alu_res = ~(op_a | op_b);
`ifdef ALU_MUL_EN
         4'd8: is_mul = 1'b1;
`endif
         default: bad = 1'b1;
      endcase
   end
`ifdef ALU_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);
   logic [WIDTH-1:0] ma, mb, acc;
   logic [CW-1:0] cnt;
   assign go_st = is_mul ? MUL : DONE;
   assign mul_done = state == MUL && cnt == CW'(WIDTH);
   assign mul_res = acc;
   // Multiplicand shifts left and multiplier right, so step i adds op_a<<i when op_b[i] is set.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ma <= '0;
         mb <= '0;
         acc <= '0;
         cnt <= '0;
      end else if (accept && is_mul) begin
         ma <= op_a;
         mb <= op_b;
         acc <= '0;
         cnt <= '0;
      end else if (state == MUL && !mul_done) begin
         acc <= acc + (mb[0] ? ma : '0);
         ma <= ma << 1;
         mb <= mb >> 1;
         cnt <= cnt + CW'(1);
      end
`else
   assign go_st = DONE;
   assign mul_done = 1'b0;
   assign mul_res = '0;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = accept ? go_st : IDLE;
         DONE: state_nx = !out_ready ? DONE : in_valid ? go_st : IDLE;
`ifdef ALU_MUL_EN
         MUL: state_nx = mul_done ? DONE : MUL;
`endif
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         result <= '0;
         zero <= 1'b0;
         illegal <= 1'b0;
      end else if (accept && !is_mul) begin
         result <= alu_res;
         zero <= !bad && alu_res == '0;
         illegal <= bad;
      end else if (mul_done) begin
         result <= mul_res;
         zero <= mul_res == '0;
         illegal <= 1'b0;
      end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed plus randomized checks of alu_exec against a behavioural model.
module tb_alu_exec;
   localparam int W = 32;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid, zero, illegal;
   logic [3:0] alu_ctl = '0;
   logic [W-1:0] op_a = '0, op_b = '0, result;
   int checks = 0, failures = 0;

   alu_exec #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_ctl(alu_ctl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic z, output logic il, output int lat);
      longint unsigned p;
      il = 1'b0;
      lat = 1;
      r = '0;
      case (c)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd2: r = a + b;
         4'd3, 4'd6: r = a - b;
         4'd7: r = ($signed(a) < $signed(b)) ? 1 : 0;
         4'd12: r = ~(a | b);
         4'd8: if (MUL_EN) begin
            p = longint'(a) * longint'(b);
            r = p[W-1:0];
            lat = W + 1;
         end else il = 1'b1;
         default: il = 1'b1;
      endcase
      z = !il && r == 0;
   endfunction

   // Single operation: wait for ready, accept, scramble inputs, measure latency and check outputs.
   task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] er;
      logic ez, ei;
      int el, n;
      model(c, a, b, er, ez, ei, el);
      @(negedge clk);
      alu_ctl = c; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      check({tag, "/in_ready"}, 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0; alu_ctl = 4'($urandom); op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      n = 1;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      check({tag, "/latency"}, 64'(n), 64'(el));
      check({tag, "/result"}, 64'(result), 64'(er));
      check({tag, "/zero"}, 64'(zero), 64'(ez));
      check({tag, "/illegal"}, 64'(illegal), 64'(ei));
   endtask

   logic [3:0] bc [3] = '{4'd2, 4'd6, 4'd3};
   logic [W-1:0] ba [3] = '{32'd5, 32'd7, 32'h10};
   logic [W-1:0] bb [3] = '{32'd7, 32'd7, 32'h10};
   logic [3:0] legal [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd12, 4'd8};

   initial begin
      logic [W-1:0] er;
      logic ez, ei;
      int el;
      #1;
      check("rst/out_valid", 64'(out_valid), 64'(0));
      check("rst/result", 64'(result), 64'(0));
      check("rst/zero", 64'(zero), 64'(0));
      check("rst/illegal", 64'(illegal), 64'(0));
      #13 rst_n = 1'b1;
      #1 check("rst/in_ready", 64'(in_ready), 64'(1));

      run_op("slt", 4'd7, 32'hFFFF_FFFF, 32'd1);
      run_op("wrap", 4'd2, 32'hFFFF_FFFF, 32'd1);
      run_op("nor", 4'd12, 32'd0, 32'd0);
      run_op("ill15", 4'd15, 32'd3, 32'd4);
      run_op("ill4", 4'd4, 32'd9, 32'd9);
      run_op("clr_ill", 4'd1, 32'd0, 32'd0);
      run_op("mul_a", 4'd8, 32'd123, 32'd456);
      run_op("mul_b", 4'd8, 32'hFFFF_FFFF, 32'd2);

      // Back-to-back accepts with out_ready held high.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            model(bc[i-1], ba[i-1], bb[i-1], er, ez, ei, el);
            check($sformatf("b2b%0d/out_valid", i-1), 64'(out_valid), 64'(1));
            check($sformatf("b2b%0d/result", i-1), 64'(result), 64'(er));
            check($sformatf("b2b%0d/zero", i-1), 64'(zero), 64'(ez));
         end
         if (i < 3) begin
            alu_ctl = bc[i]; op_a = ba[i]; op_b = bb[i]; in_valid = 1'b1; out_ready = 1'b1;
            #1 check($sformatf("b2b%0d/in_ready", i), 64'(in_ready), 64'(1));
         end else in_valid = 1'b0;
      end

      // Backpressure: result must hold while the next op waits.
      @(negedge clk);
      alu_ctl = 4'd0; op_a = 32'hF0F0; op_b = 32'hFF00; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; alu_ctl = 4'd2; op_a = 32'd100; op_b = 32'd23;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("bp%0d/result", i), 64'(result), 64'hF000);
         check($sformatf("bp%0d/in_ready", i), 64'(in_ready), 64'(0));
         check($sformatf("bp%0d/out_valid", i), 64'(out_valid), 64'(1));
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 check("bp/release_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      in_valid = 1'b0;
      check("bp/queued_result", 64'(result), 64'(123));

      // Reset in the middle of a long operation (multiply, or a stalled ADD without the multiplier).
      run_op("pre_rst", 4'd2, 32'd5, 32'd7);
      @(negedge clk);
      alu_ctl = MUL_EN ? 4'd8 : 4'd2; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("mid/out_valid", 64'(out_valid), 64'(!MUL_EN));
      rst_n = 1'b0;
      #1;
      check("mid/rst_out_valid", 64'(out_valid), 64'(0));
      check("mid/rst_result", 64'(result), 64'(0));
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      #1 check("mid/in_ready", 64'(in_ready), 64'(1));
      run_op("post_rst", 4'd6, 32'd50, 32'd8);

      // Randomized ops, biased toward legal codes and edge operands.
      for (int i = 0; i < 40; i++) begin
         logic [3:0] c;
         logic [W-1:0] a, b;
         c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal[$urandom_range(0, 7)];
         a = $urandom;
         b = ($urandom_range(0, 4) == 0) ? a : W'($urandom);
         if ($urandom_range(0, 5) == 0) a = '0;
         run_op($sformatf("rnd%0d", i), c, a, b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
